// File: rtl/axis_pkt_fifo_pkg.sv
// Shared constants and helpers for the AXI-Stream packet FIFO.
// Holds the mode encodings, default widths and the stored-entry width calculation.
package axis_pkt_fifo_pkg;

    localparam int MODE_CUT_THROUGH = 0;
    localparam int MODE_STORE_FWD   = 1;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_DEPTH       = 16;
    localparam int DEF_TID_WIDTH   = 8;
    localparam int DEF_TDEST_WIDTH = 4;
    localparam int DEF_TUSER_WIDTH = 4;

    // tdata + tstrb + tkeep + tlast + tid + tdest + tuser
    function automatic int entry_width(input int dw, input int idw, input int dstw, input int usrw);
        return dw + 2 * (dw / 8) + 1 + idw + dstw + usrw;
    endfunction

endpackage

// File: rtl/axis_out_reg_slice.sv
// axis_out_reg_slice: one-entry register stage between the FIFO memory head and the master port.
// Latency: 1 cycle from in_vld to out_vld.
// Backpressure: in_rdy = !out_vld | out_rdy, so the slice reloads on the same cycle it drains.
module axis_out_reg_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dat_q, dat_d;
    logic             load;

    assign in_rdy  = !vld_q || out_rdy;
    assign load    = in_vld && in_rdy;
    assign out_vld = vld_q;
    assign out_dat = dat_q;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (load) begin
            vld_d = 1'b1;
            dat_d = in_dat;
        end else if (out_rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

endmodule

// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: AXI-Stream FIFO, cut-through or store-and-forward, with level/packet status.
// Latency: 1 cycle write-to-valid; 2 cycles when AXIS_PKT_FIFO_OUT_REG_EN adds the output slice.
// Backpressure: s_axis_tready = !full (low during reset and one cycle after); m_axis_* held while stalled.
module axis_pkt_fifo
    import axis_pkt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int TID_WIDTH   = DEF_TID_WIDTH,
    parameter int TDEST_WIDTH = DEF_TDEST_WIDTH,
    parameter int TUSER_WIDTH = DEF_TUSER_WIDTH,
    parameter int PACKET_MODE = MODE_CUT_THROUGH,
    parameter int AF_THRESH   = DEPTH - 2,
    parameter int AE_THRESH   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tstrb,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                      s_axis_tlast,
    input  logic [TID_WIDTH-1:0]      s_axis_tid,
    input  logic [TDEST_WIDTH-1:0]    s_axis_tdest,
    input  logic [TUSER_WIDTH-1:0]    s_axis_tuser,

    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tstrb,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic [TID_WIDTH-1:0]      m_axis_tid,
    output logic [TDEST_WIDTH-1:0]    m_axis_tdest,
    output logic [TUSER_WIDTH-1:0]    m_axis_tuser,

    output logic [$clog2(DEPTH):0]    level,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [$clog2(DEPTH):0]    pkt_count,
    output logic                      release_active
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int KW = DATA_WIDTH / 8;
    localparam int EW = entry_width(DATA_WIDTH, TID_WIDTH, TDEST_WIDTH, TUSER_WIDTH);
    localparam bit SF = (PACKET_MODE == MODE_STORE_FWD);

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  tdata;
        logic [KW-1:0]          tstrb;
        logic [KW-1:0]          tkeep;
        logic                   tlast;
        logic [TID_WIDTH-1:0]   tid;
        logic [TDEST_WIDTH-1:0] tdest;
        logic [TUSER_WIDTH-1:0] tuser;
    } beat_t;

    logic [EW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d, pkt_cnt_q, pkt_cnt_d;
    logic          rel_q, rel_d, af_q, af_d, ae_q, ae_d, rdy_en_q;

    beat_t s_beat, head_beat, m_beat;
    logic  full, empty, wr_fire, head_vld, head_rdy, rd_fire, wr_tlast, rd_tlast;

    assign s_beat = '{tdata: s_axis_tdata, tstrb: s_axis_tstrb, tkeep: s_axis_tkeep,
                      tlast: s_axis_tlast, tid: s_axis_tid, tdest: s_axis_tdest,
                      tuser: s_axis_tuser};

    assign full          = (level_q == DEPTH_L);
    assign empty         = (level_q == '0);
    assign s_axis_tready = rdy_en_q && !full;
    assign wr_fire       = s_axis_tvalid && s_axis_tready;

    // In store-and-forward the head is only offered once a whole packet (or an oversize release) is present.
    assign head_beat = beat_t'(mem_q[rd_ptr_q]);
    assign head_vld  = !empty && (!SF || (pkt_cnt_q != '0) || rel_q);
    assign rd_fire   = head_vld && head_rdy;
    assign wr_tlast  = wr_fire && s_axis_tlast;
    assign rd_tlast  = rd_fire && head_beat.tlast;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        pkt_cnt_d = pkt_cnt_q;

        if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);

        if (wr_fire && !rd_fire)      level_d = level_q + LW'(1);
        else if (!wr_fire && rd_fire) level_d = level_q - LW'(1);

        if (wr_tlast && !rd_tlast)      pkt_cnt_d = pkt_cnt_q + LW'(1);
        else if (!wr_tlast && rd_tlast) pkt_cnt_d = pkt_cnt_q - LW'(1);

        // A full memory with no complete packet can never drain on its own, so stream it out.
        rel_d = SF && ((rel_q && !rd_tlast) || ((level_d == DEPTH_L) && (pkt_cnt_d == '0)));
        af_d  = (level_d >= AF_L);
        ae_d  = (level_d <= AE_L);
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_ptr_q] <= s_beat;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            pkt_cnt_q <= '0;
            rel_q     <= 1'b0;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
            rdy_en_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            pkt_cnt_q <= pkt_cnt_d;
            rel_q     <= rel_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
            rdy_en_q  <= 1'b1;
        end
    end

`ifdef AXIS_PKT_FIFO_OUT_REG_EN
    logic [EW-1:0] slice_dat;

    axis_out_reg_slice #(
        .WIDTH (EW)
    ) u_out_slice (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (head_vld),
        .in_rdy  (head_rdy),
        .in_dat  (head_beat),
        .out_vld (m_axis_tvalid),
        .out_rdy (m_axis_tready),
        .out_dat (slice_dat)
    );

    assign m_beat = beat_t'(slice_dat);
`else
    assign m_axis_tvalid = head_vld;
    assign head_rdy      = m_axis_tready;
    assign m_beat        = head_beat;
`endif

    assign m_axis_tdata   = m_beat.tdata;
    assign m_axis_tstrb   = m_beat.tstrb;
    assign m_axis_tkeep   = m_beat.tkeep;
    assign m_axis_tlast   = m_beat.tlast;
    assign m_axis_tid     = m_beat.tid;
    assign m_axis_tdest   = m_beat.tdest;
    assign m_axis_tuser   = m_beat.tuser;

    assign level          = level_q;
    assign pkt_count      = pkt_cnt_q;
    assign release_active = rel_q;
    assign almost_full    = af_q;
    assign almost_empty   = ae_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: instance 0 runs cut-through, instance 1 store-and-forward.
// Output beats are checked against a per-instance queue of accepted input beats.
module tb_axis_pkt_fifo;

`ifdef AXIS_PKT_FIFO_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif
    localparam int NFILL = 16 + LAT;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic        last;
        logic [7:0]  id;
        logic [3:0]  dest;
        logic [3:0]  user;
    } tb_beat_t;

    logic        clk, rst_n;
    logic        s_vld [2];
    logic        s_rdy [2];
    tb_beat_t    s_b   [2];
    logic        m_vld [2];
    logic        m_rdy [2];
    logic [31:0] m_data [2];
    logic [3:0]  m_strb [2];
    logic [3:0]  m_keep [2];
    logic        m_last [2];
    logic [7:0]  m_id   [2];
    logic [3:0]  m_dest [2];
    logic [3:0]  m_user [2];
    logic [4:0]  level_o [2];
    logic [4:0]  pkt_o   [2];
    logic        af_o  [2];
    logic        ae_o  [2];
    logic        rel_o [2];

    int tests = 0;
    int fails = 0;
    tb_beat_t sb0 [$];
    tb_beat_t sb1 [$];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        axis_pkt_fifo #(
            .PACKET_MODE (gi)
        ) dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .s_axis_tvalid  (s_vld[gi]),
            .s_axis_tready  (s_rdy[gi]),
            .s_axis_tdata   (s_b[gi].data),
            .s_axis_tstrb   (s_b[gi].strb),
            .s_axis_tkeep   (s_b[gi].keep),
            .s_axis_tlast   (s_b[gi].last),
            .s_axis_tid     (s_b[gi].id),
            .s_axis_tdest   (s_b[gi].dest),
            .s_axis_tuser   (s_b[gi].user),
            .m_axis_tvalid  (m_vld[gi]),
            .m_axis_tready  (m_rdy[gi]),
            .m_axis_tdata   (m_data[gi]),
            .m_axis_tstrb   (m_strb[gi]),
            .m_axis_tkeep   (m_keep[gi]),
            .m_axis_tlast   (m_last[gi]),
            .m_axis_tid     (m_id[gi]),
            .m_axis_tdest   (m_dest[gi]),
            .m_axis_tuser   (m_user[gi]),
            .level          (level_o[gi]),
            .almost_full    (af_o[gi]),
            .almost_empty   (ae_o[gi]),
            .pkt_count      (pkt_o[gi]),
            .release_active (rel_o[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic tb_beat_t mk(input logic [31:0] d, input logic l);
        tb_beat_t b;
        b.data = d;
        b.strb = d[3:0];
        b.keep = ~d[7:4];
        b.last = l;
        b.id   = d[7:0] ^ 8'hA5;
        b.dest = d[11:8];
        b.user = d[3:0] + 4'd3;
        return b;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int g, input tb_beat_t b);
        bit acc;
        acc = 1'b0;
        s_vld[g] = 1'b1;
        s_b[g]   = b;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = s_rdy[g];
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: dut %0d beat %h not accepted", g, b.data);
        end
    endtask

    task automatic drain(input int g);
        bit done;
        done = 1'b0;
        s_vld[g] = 1'b0;
        m_rdy[g] = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            step();
            done = (level_o[g] == 5'd0) && !m_vld[g];
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: dut %0d level %0d m_tvalid %0b", g, level_o[g], m_vld[g]);
        end
    endtask

    task automatic mon_out(input int g);
        tb_beat_t act, exp_b;
        act.data = m_data[g];
        act.strb = m_strb[g];
        act.keep = m_keep[g];
        act.last = m_last[g];
        act.id   = m_id[g];
        act.dest = m_dest[g];
        act.user = m_user[g];
        tests++;
        if ((g == 0 && sb0.size() == 0) || (g == 1 && sb1.size() == 0)) begin
            fails++;
            $display("FAIL out_unexpected: dut %0d emitted %h with nothing expected", g, act);
            return;
        end
        exp_b = (g == 0) ? sb0.pop_front() : sb1.pop_front();
        if (act !== exp_b) begin
            fails++;
            $display("FAIL out_beat: dut %0d got %h expected %h", g, act, exp_b);
        end
    endtask

    // Scoreboard: accepted input beats are queued, every output handshake is compared in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb0.delete();
            sb1.delete();
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (m_vld[g] && m_rdy[g]) mon_out(g);
                if (s_vld[g] && s_rdy[g]) begin
                    if (g == 0) sb0.push_back(s_b[0]);
                    else        sb1.push_back(s_b[1]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lv;
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            s_vld[g] = 1'b0;
            m_rdy[g] = 1'b0;
            s_b[g]   = mk(32'h0, 1'b0);
        end
        step();
        step();
        for (int g = 0; g < 2; g++) begin
            chk("rst_level", int'(level_o[g]), 0);
            chk("rst_pkt_count", int'(pkt_o[g]), 0);
            chk("rst_release", int'(rel_o[g]), 0);
            chk("rst_almost_empty", int'(ae_o[g]), 1);
            chk("rst_almost_full", int'(af_o[g]), 0);
            chk("rst_m_tvalid", int'(m_vld[g]), 0);
            chk("rst_s_tready", int'(s_rdy[g]), 0);
        end
        rst_n = 1'b1;
        chk("post_rst_tready_low", int'(s_rdy[0]), 0);
        step();
        chk("post_rst_tready_high", int'(s_rdy[0]), 1);

        // Cut-through streaming, one beat per cycle.
        m_rdy[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(0, mk(32'h11 + i, 1'b0));
            chk("ct_level", int'(level_o[0]), 1);
            chk("ct_m_tvalid", int'(m_vld[0]), int'((i > 0) || (LAT == 0)));
        end
        drain(0);

        // Fill to full, hold the next beat, free one slot.
        m_rdy[0] = 1'b0;
        for (int i = 0; i < NFILL; i++) begin
            send(0, mk(32'h100 + i, 1'b0));
            lv = (i == 0) ? 1 : i + 1 - LAT;
            chk("fill_level", int'(level_o[0]), lv);
            chk("fill_s_tready", int'(s_rdy[0]), int'(lv != 16));
            chk("fill_almost_full", int'(af_o[0]), int'(lv >= 14));
            chk("fill_almost_empty", int'(ae_o[0]), int'(lv <= 2));
        end
        s_vld[0] = 1'b1;
        s_b[0]   = mk(32'h1FF, 1'b1);
        step();
        chk("full_held_tready", int'(s_rdy[0]), 0);
        chk("full_held_level", int'(level_o[0]), 16);
        m_rdy[0] = 1'b1;
        step();
        m_rdy[0] = 1'b0;
        chk("full_read_level", int'(level_o[0]), 15);
        chk("full_read_tready", int'(s_rdy[0]), 1);
        step();
        chk("full_refill_level", int'(level_o[0]), 16);
        chk("full_refill_pkt", int'(pkt_o[0]), 1);
        drain(0);
        chk("full_drain_pkt", int'(pkt_o[0]), 0);

        // Store-and-forward: 3-beat packet.
        m_rdy[1] = 1'b1;
        send(1, mk(32'h201, 1'b0));
        chk("sf_b1_m_tvalid", int'(m_vld[1]), 0);
        send(1, mk(32'h202, 1'b0));
        chk("sf_b2_m_tvalid", int'(m_vld[1]), 0);
        chk("sf_b2_pkt", int'(pkt_o[1]), 0);
        send(1, mk(32'h203, 1'b1));
        s_vld[1] = 1'b0;
        chk("sf_b3_pkt", int'(pkt_o[1]), 1);
        chk("sf_b3_level", int'(level_o[1]), 3);
        chk("sf_b3_m_tvalid", int'(m_vld[1]), int'(LAT == 0));
        step();
        chk("sf_rd1_level", int'(level_o[1]), 2);
        chk("sf_rd1_m_tvalid", int'(m_vld[1]), 1);
        chk("sf_rd1_pkt", int'(pkt_o[1]), 1);
        step();
        chk("sf_rd2_level", int'(level_o[1]), 1);
        step();
        chk("sf_rd3_level", int'(level_o[1]), 0);
        chk("sf_rd3_pkt", int'(pkt_o[1]), 0);
        drain(1);

        // Oversize packet: 20 beats, single tlast.
        m_rdy[1] = 1'b0;
        for (int i = 0; i < 16; i++) send(1, mk(32'h300 + i, 1'b0));
        chk("ovr_level", int'(level_o[1]), 16);
        chk("ovr_release", int'(rel_o[1]), 1);
        chk("ovr_pkt", int'(pkt_o[1]), 0);
        chk("ovr_s_tready", int'(s_rdy[1]), 0);
        chk("ovr_m_tvalid", int'(m_vld[1]), int'(LAT == 0));
        m_rdy[1] = 1'b1;
        for (int i = 16; i < 20; i++) send(1, mk(32'h300 + i, i == 19));
        chk("ovr_tlast_wr_release", int'(rel_o[1]), 1);
        chk("ovr_tlast_wr_pkt", int'(pkt_o[1]), 1);
        drain(1);
        chk("ovr_done_release", int'(rel_o[1]), 0);
        chk("ovr_done_pkt", int'(pkt_o[1]), 0);

        // Simultaneous read and write at level 5, tlast on both sides.
        m_rdy[0] = 1'b0;
        for (int i = 0; i < LAT; i++) send(0, mk(32'h3F0, 1'b0));
        send(0, mk(32'h400, 1'b1));
        for (int i = 1; i < 5; i++) send(0, mk(32'h400 + i, 1'b0));
        chk("rw_pre_level", int'(level_o[0]), 5);
        chk("rw_pre_pkt", int'(pkt_o[0]), 1);
        m_rdy[0] = 1'b1;
        send(0, mk(32'h405, 1'b1));
        chk("rw_level", int'(level_o[0]), 5);
        chk("rw_pkt", int'(pkt_o[0]), 1);
        drain(0);
        chk("rw_drain_pkt", int'(pkt_o[0]), 0);

        // Pointer wrap: 40 beats streamed through.
        for (int i = 0; i < 40; i++) send(0, mk(32'h500 + i, (i % 8) == 7));
        drain(0);
        chk("wrap_level", int'(level_o[0]), 0);
        chk("wrap_pkt", int'(pkt_o[0]), 0);

        // Reset in the middle of a packet.
        m_rdy[1] = 1'b1;
        send(1, mk(32'h600, 1'b0));
        send(1, mk(32'h601, 1'b0));
        chk("mid_level", int'(level_o[1]), 2);
        s_vld[1] = 1'b0;
        rst_n = 1'b0;
        step();
        chk("mid_rst_level", int'(level_o[1]), 0);
        chk("mid_rst_pkt", int'(pkt_o[1]), 0);
        chk("mid_rst_m_tvalid", int'(m_vld[1]), 0);
        rst_n = 1'b1;
        chk("mid_rel_tready_low", int'(s_rdy[1]), 0);
        step();
        chk("mid_rel_tready_high", int'(s_rdy[1]), 1);
        for (int i = 0; i < 4; i++) send(1, mk(32'h610 + i, i == 3));
        drain(1);
        chk("mid_new_pkt", int'(pkt_o[1]), 0);

        step();
        chk("sb0_empty", sb0.size(), 0);
        chk("sb1_empty", sb1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_pkt_fifo.md
Name: axis_pkt_fifo

Overview:
- Parametrised AXI-Stream FIFO, successor to the basic single-mode stream FIFO.
- Adds a store-and-forward packet mode, oversize-packet release, occupancy/threshold status, and an optional registered output slice.
- Sits between AXI-Stream producers and consumers, carrying full sideband: tdata/tstrb/tkeep/tlast/tid/tdest/tuser.

Parameters:
- DATA_WIDTH, 32: tdata width; multiple of 8; tstrb/tkeep width = DATA_WIDTH/8.
- DEPTH, 16: entries; power of two, >= 2; ADDR_WIDTH = $clog2(DEPTH).
- TID_WIDTH, 8: tid width.
- TDEST_WIDTH, 4: tdest width.
- TUSER_WIDTH, 4: tuser width.
- PACKET_MODE, 0: 0 = cut-through; 1 = store-and-forward.
- AF_THRESH, DEPTH-2: almost_full asserts when level >= AF_THRESH.
- AE_THRESH, 2: almost_empty asserts when level <= AE_THRESH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- s_axis_tvalid/tready/tdata/tstrb/tkeep/tlast/tid/tdest/tuser  in/out/in...  per parameters  slave stream.
- m_axis_tvalid/tready/tdata/tstrb/tkeep/tlast/tid/tdest/tuser  out/in/out...  per parameters  master stream.
- level  out  ADDR_WIDTH+1  entries stored in the memory.
- almost_full  out  1  level >= AF_THRESH.
- almost_empty  out  1  level <= AE_THRESH.
- pkt_count  out  ADDR_WIDTH+1  complete packets (tlast written, not yet read).
- release_active  out  1  oversize-packet release in progress.

Behaviour:
- Clocking/reset: single clock `clk`; reset is synchronous, active-low on `rst_n`, sampled at posedge clk.
- Reset state: wr_ptr, rd_ptr, level, pkt_count = 0; release_active = 0; almost_empty = 1; almost_full = 0; m_axis_tvalid = 0.
- s_axis_tready = 0 while rst_n is low and for the first cycle after release; then tready = !full.
- Memory contents are not reset.
- Write: when s_tvalid & s_tready, store the beat at wr_ptr and increment wr_ptr; the pointer wraps modulo DEPTH.
- Read: when m_tvalid & m_tready, increment rd_ptr (wrapping). m_axis_* data comes combinationally from mem[rd_ptr].
- level: write-only = +1; read-only = -1; simultaneous or none = unchanged. full = (level == DEPTH), empty = (level == 0).
- pkt_count: +1 on a write beat with tlast; -1 on a read beat with tlast; both in the same cycle = unchanged.
- Cut-through (PACKET_MODE=0): m_tvalid = !empty. Latency is 1 cycle: a beat written at edge N is valid after edge N.
- Store-and-forward (PACKET_MODE=1): m_tvalid = !empty & (pkt_count != 0 | release_active).
  - m_tvalid rises the cycle after the tlast beat is written.
  - Once asserted, m_tvalid stays high until the tlast beat of that packet is read; tvalid is never dropped mid-packet.
- Oversize release (PACKET_MODE=1 only):
  - release_active sets when full & pkt_count == 0, since the packet is larger than DEPTH and would deadlock.
  - It clears on the read of a tlast beat.
  - While active, the FIFO behaves as cut-through.
- Simultaneous read and write when full: tready = 0, so only the read occurs. When empty, no read is possible.
- Status outputs are registered: they reflect the post-edge state.
- Reset mid-packet discards all stored beats and partial packets; the next packet starts clean.
- A sender must not change the beat while tvalid is high and tready is low. The FIFO holds m_axis_* stable while m_tvalid & !m_tready.

Optional Feature:
- Macro: AXIS_PKT_FIFO_OUT_REG_EN.
- Defined: m_axis_* are driven from a 1-entry register slice fed from the memory head.
  - Latency becomes 2 cycles (write at N, valid after N+1).
  - Effective capacity is DEPTH+1; level counts memory entries only.
  - Full throughput is retained: slice reloads on the same cycle it is drained.
  - Slice cleared to invalid on reset.
- Undefined: combinational output from memory as described above.

Decomposition:
- Package axis_pkt_fifo_pkg:
  - mode localparams (MODE_CUT_THROUGH = 0, MODE_STORE_FWD = 1).
  - default width constants.
  - function computing entry width from the widths.
- Beat struct stays in the module, since it depends on parameters.
- One sub-module, axis_out_reg_slice: the registered output slice, instantiated only under AXIS_PKT_FIFO_OUT_REG_EN.

Test Plan:
- Cut-through, DEPTH=16: write beats 0x11..0x14, m_tready=1 → each appears 1 cycle after its write, in order, sideband intact; level peaks at 1.
- Fill/full: m_tready=0, push 16 beats → level=16, s_tready=0, almost_full=1 from level 14; 17th beat held; one read → s_tready=1 next cycle.
- Store-and-forward: 3-beat packet, tlast on beat 3 → m_tvalid stays 0 until the cycle after beat 3; then pkt_count=1; 3 beats drain back-to-back; pkt_count returns to 0.
- Oversize packet: 20 beats, single tlast → at level=16, release_active=1 and m_tvalid=1; all 20 beats delivered; release_active=0 after the tlast read.
- Simultaneous read/write at level=5 with a tlast written and another read in the same cycle → level=5, pkt_count unchanged; pointer wrap after 40 beats → data order preserved.
- Reset mid-packet: 2 of 4 beats written, rst_n low 1 cycle → level=0, pkt_count=0, m_tvalid=0; s_tready=0 for one cycle after release; a new packet passes correctly.
